// File: rtl/fproc_meas_pkg.sv
// Shared types and helpers for the fproc measurement responder.
package fproc_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned RESULT_MAX = 64;

  // Keeps only the low `width` bits of a result; callers narrow to their data width.
  function automatic logic [RESULT_MAX-1:0] zero_extend(
    input logic [RESULT_MAX-1:0] value,
    input int unsigned           width
  );
    logic [RESULT_MAX-1:0] mask;
    mask = (width >= RESULT_MAX) ? '1
                                 : ((RESULT_MAX'(1) << width) - RESULT_MAX'(1));
    return value & mask;
  endfunction

endpackage

// File: rtl/fproc_meas_port.sv
// Per-core fproc responder: accepts one request, waits for a fresh result, answers.
module fproc_meas_port
  import fproc_meas_pkg::*;
#(
  parameter int unsigned N_MEAS             = 8,
  parameter int unsigned FPROC_ID_WIDTH     = 8,
  parameter int unsigned FPROC_RESULT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [FPROC_ID_WIDTH-1:0]     id,
  input  logic                          fresh_sel,
  input  logic [FPROC_RESULT_WIDTH-1:0] res_sel,
  output logic [FPROC_ID_WIDTH-1:0]     id_q,
  output logic                          consume,
  output logic                          ready,
  output logic [FPROC_RESULT_WIDTH-1:0] data,
  output logic                          err
);

  localparam logic [FPROC_ID_WIDTH:0] ID_LIMIT = (FPROC_ID_WIDTH+1)'(N_MEAS);

  state_t state;
  logic   in_range;

  always_comb begin
    in_range = {1'b0, id_q} < ID_LIMIT;
    consume  = (state == WAIT) && in_range && fresh_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      id_q  <= '0;
      ready <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            id_q  <= id;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (enable) err <= 1'b1;
          if (!in_range) begin
            data  <= '0;
            err   <= 1'b1;
            ready <= 1'b1;
            state <= RESP;
          end else if (fresh_sel) begin
            data  <= res_sel;
            ready <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (enable) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fproc_meas_hub.sv
// Measurement result hub answering fproc requests from N_CORES independent cores.
module fproc_meas_hub
  import fproc_meas_pkg::*;
#(
  parameter int unsigned N_CORES            = 4,
  parameter int unsigned N_MEAS             = 8,
  parameter int unsigned FPROC_ID_WIDTH     = 8,
  parameter int unsigned FPROC_RESULT_WIDTH = 32,
  parameter int unsigned MEAS_WIDTH         = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0]     fproc_id,
  input  logic [N_CORES-1:0]                    fproc_enable,
  output logic [N_CORES-1:0]                    fproc_ready,
  output logic [N_CORES*FPROC_RESULT_WIDTH-1:0] fproc_data,
  output logic [N_CORES-1:0]                    fproc_err,
  input  logic [N_MEAS*MEAS_WIDTH-1:0]          meas_data,
  input  logic [N_MEAS-1:0]                     meas_valid
);

  logic [MEAS_WIDTH-1:0]         res       [N_MEAS];
  logic [N_MEAS-1:0]             fresh     [N_CORES];
  logic [FPROC_ID_WIDTH-1:0]     id_q      [N_CORES];
  logic [FPROC_RESULT_WIDTH-1:0] res_sel   [N_CORES];
  logic [N_CORES-1:0]            fresh_sel;
  logic [N_CORES-1:0]            consume;

  // Out-of-range ids match no channel, so they see fresh=0 and data=0.
  always_comb begin
    for (int unsigned c = 0; c < N_CORES; c++) begin
      fresh_sel[c] = 1'b0;
      res_sel[c]   = '0;
      for (int unsigned k = 0; k < N_MEAS; k++) begin
        if (id_q[c] == FPROC_ID_WIDTH'(k)) begin
          fresh_sel[c] = fresh[c][k];
          res_sel[c]   = FPROC_RESULT_WIDTH'(zero_extend(RESULT_MAX'(res[k]), MEAS_WIDTH));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < N_MEAS; k++) res[k] <= '0;
      for (int unsigned c = 0; c < N_CORES; c++) fresh[c] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_MEAS; k++) begin
        if (meas_valid[k]) res[k] <= meas_data[k*MEAS_WIDTH +: MEAS_WIDTH];
      end
      // A new result outranks a consume landing in the same cycle.
      for (int unsigned c = 0; c < N_CORES; c++) begin
        for (int unsigned k = 0; k < N_MEAS; k++) begin
          if (meas_valid[k])
            fresh[c][k] <= 1'b1;
          else if (consume[c] && id_q[c] == FPROC_ID_WIDTH'(k))
            fresh[c][k] <= 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_port
    fproc_meas_port #(
      .N_MEAS            (N_MEAS),
      .FPROC_ID_WIDTH    (FPROC_ID_WIDTH),
      .FPROC_RESULT_WIDTH(FPROC_RESULT_WIDTH)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .enable   (fproc_enable[c]),
      .id       (fproc_id[c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH]),
      .fresh_sel(fresh_sel[c]),
      .res_sel  (res_sel[c]),
      .id_q     (id_q[c]),
      .consume  (consume[c]),
      .ready    (fproc_ready[c]),
      .data     (fproc_data[c*FPROC_RESULT_WIDTH +: FPROC_RESULT_WIDTH]),
      .err      (fproc_err[c])
    );
  end

endmodule

// File: tb/tb_fproc_meas_hub.sv
// Directed bench for fproc_meas_hub with a transaction-level reference model.
module tb_fproc_meas_hub;

  localparam int NC = 4;
  localparam int NM = 8;
  localparam int IW = 8;
  localparam int RW = 32;
  localparam int MW = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*IW-1:0] fproc_id;
  logic [NC-1:0]    fproc_enable;
  logic [NC-1:0]    fproc_ready;
  logic [NC*RW-1:0] fproc_data;
  logic [NC-1:0]    fproc_err;
  logic [NM*MW-1:0] meas_data;
  logic [NM-1:0]    meas_valid;

  int compares   = 0;
  int mismatches = 0;

  fproc_meas_hub #(
    .N_CORES           (NC),
    .N_MEAS            (NM),
    .FPROC_ID_WIDTH    (IW),
    .FPROC_RESULT_WIDTH(RW),
    .MEAS_WIDTH        (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fproc_id    (fproc_id),
    .fproc_enable(fproc_enable),
    .fproc_ready (fproc_ready),
    .fproc_data  (fproc_data),
    .fproc_err   (fproc_err),
    .meas_data   (meas_data),
    .meas_valid  (meas_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] dat(input int c);
    return fproc_data[c*RW +: RW];
  endfunction

  // Reference model: a core is busy from acceptance until its ready cycle ends;
  // it is answered at the first edge where its channel is fresh for it.
  logic [MW-1:0] res_m     [NM];
  bit            fresh_m   [NC][NM];
  bit            busy_m    [NC];
  bit            waiting_m [NC];
  int            pid_m     [NC];
  logic [NC-1:0] ready_m;
  logic [NC-1:0] err_m;
  logic [RW-1:0] data_m    [NC];

  task automatic model_reset();
    for (int k = 0; k < NM; k++) res_m[k] = '0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < NM; k++) fresh_m[c][k] = 0;
      busy_m[c]    = 0;
      waiting_m[c] = 0;
      pid_m[c]     = 0;
      data_m[c]    = '0;
    end
    ready_m = '0;
    err_m   = '0;
  endtask

  task automatic model_step();
    bit clr [NC][NM];
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NM; k++) clr[c][k] = 0;
    for (int c = 0; c < NC; c++) begin
      ready_m[c] = 1'b0;
      if (!busy_m[c]) begin
        if (fproc_enable[c]) begin
          busy_m[c]    = 1;
          waiting_m[c] = 1;
          pid_m[c]     = int'(fproc_id[c*IW +: IW]);
        end
      end else begin
        if (fproc_enable[c]) err_m[c] = 1'b1;
        if (!waiting_m[c]) begin
          busy_m[c] = 0;
        end else if (pid_m[c] >= NM) begin
          data_m[c]    = '0;
          err_m[c]     = 1'b1;
          waiting_m[c] = 0;
          ready_m[c]   = 1'b1;
        end else if (fresh_m[c][pid_m[c]]) begin
          data_m[c]            = RW'(res_m[pid_m[c]]);
          clr[c][pid_m[c]]     = 1;
          waiting_m[c]         = 0;
          ready_m[c]           = 1'b1;
        end
      end
    end
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NM; k++)
        if (clr[c][k]) fresh_m[c][k] = 0;
    for (int k = 0; k < NM; k++) begin
      if (meas_valid[k]) begin
        res_m[k] = meas_data[k*MW +: MW];
        for (int c = 0; c < NC; c++) fresh_m[c][k] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("model_ready", 64'(fproc_ready), 64'(ready_m));
    check("model_err", 64'(fproc_err), 64'(err_m));
    for (int c = 0; c < NC; c++)
      check($sformatf("model_data%0d", c), 64'(dat(c)), 64'(data_m[c]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_meas(input int k, input logic v);
    meas_valid[k] = 1'b1;
    meas_data[k]  = v;
    tick();
    meas_valid = '0;
  endtask

  task automatic request(input int c, input int id);
    fproc_enable[c]       = 1'b1;
    fproc_id[c*IW +: IW]  = IW'(id);
    tick();
    fproc_enable = '0;
  endtask

  initial begin
    reset        = 1'b0;
    fproc_id     = '0;
    fproc_enable = '0;
    meas_data    = '0;
    meas_valid   = '0;
    repeat (3) tick();
    check("reset_ready", 64'(fproc_ready), 64'h0);
    check("reset_err", 64'(fproc_err), 64'h0);
    check("reset_data", 64'(fproc_data == '0), 64'h1);
    reset = 1'b1;
    tick();

    // Result already waiting, then a stalled second read of the same channel
    pulse_meas(3, 1'b1);
    request(0, 3);
    tick();
    check("t1_ready", 64'(fproc_ready), 64'h1);
    check("t1_data", 64'(dat(0)), 64'h1);
    tick();
    check("t1_ready_drop", 64'(fproc_ready), 64'h0);
    request(0, 3);
    repeat (5) tick();
    check("t1_stall", 64'(fproc_ready), 64'h0);
    pulse_meas(3, 1'b0);
    tick();
    check("t1_release_ready", 64'(fproc_ready), 64'h1);
    check("t1_release_data", 64'(dat(0)), 64'h0);
    tick();

    // Stall then release on core 1
    request(1, 5);
    repeat (10) tick();
    check("t2_stall", 64'(fproc_ready), 64'h0);
    pulse_meas(5, 1'b0);
    tick();
    check("t2_ready", 64'(fproc_ready), 64'h2);
    check("t2_data", 64'(dat(1)), 64'h0);
    tick();

    // Shared channel read by cores 0 and 2 together
    pulse_meas(7, 1'b1);
    fproc_enable = 4'b0101;
    fproc_id[0*IW +: IW] = 8'd7;
    fproc_id[2*IW +: IW] = 8'd7;
    tick();
    fproc_enable = '0;
    tick();
    check("t3_ready", 64'(fproc_ready), 64'h5);
    check("t3_data0", 64'(dat(0)), 64'h1);
    check("t3_data2", 64'(dat(2)), 64'h1);
    tick();
    request(0, 7);
    repeat (4) tick();
    check("t3_cleared", 64'(fproc_ready), 64'h0);
    pulse_meas(7, 1'b0);
    tick();
    check("t3_release", 64'(fproc_ready), 64'h1);
    tick();

    // New result lands on the consume cycle: old value returned, fresh kept
    pulse_meas(2, 1'b1);
    request(0, 2);
    meas_valid[2] = 1'b1;
    meas_data[2]  = 1'b0;
    tick();
    meas_valid = '0;
    check("t4_ready", 64'(fproc_ready), 64'h1);
    check("t4_old_data", 64'(dat(0)), 64'h1);
    tick();
    request(0, 2);
    tick();
    check("t4_next_ready", 64'(fproc_ready), 64'h1);
    check("t4_new_data", 64'(dat(0)), 64'h0);
    tick();

    // Out-of-range id, then an enable while waiting
    request(3, 9);
    tick();
    check("t5_bad_ready", 64'(fproc_ready), 64'h8);
    check("t5_bad_data", 64'(dat(3)), 64'h0);
    check("t5_bad_err", 64'(fproc_err), 64'h8);
    tick();
    request(2, 6);
    request(2, 7);
    tick();
    check("t5_ignored", 64'(fproc_ready), 64'h0);
    check("t5_err", 64'(fproc_err), 64'hC);
    pulse_meas(6, 1'b1);
    tick();
    check("t5_pending_ready", 64'(fproc_ready), 64'h4);
    check("t5_pending_data", 64'(dat(2)), 64'h1);
    repeat (3) tick();
    check("t5_sticky", 64'(fproc_err), 64'hC);

    // Asynchronous reset while core 1 waits
    request(1, 4);
    tick();
    #2 reset = 1'b0;
    #1;
    check("t6_async_ready", 64'(fproc_ready), 64'h0);
    check("t6_async_err", 64'(fproc_err), 64'h0);
    check("t6_async_data", 64'(fproc_data == '0), 64'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    pulse_meas(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_ready", 64'(fproc_ready), 64'h0);
      tick();
    end
    request(0, 4);
    tick();
    check("t6_after_ready", 64'(fproc_ready), 64'h1);
    check("t6_after_data", 64'(dat(0)), 64'h1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
